// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: retires P_STEP multiplier bits per cycle into a
// 2*P_N accumulator, with optional signed operands and result flags.
module mul_iter #(
  parameter int P_N    = 32,
  parameter int P_STEP = 4
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iFLUSH,
  input  logic             iVALID,
  input  logic             iSIGNED,
  input  logic [P_N-1:0]   iSOURCE0,
  input  logic [P_N-1:0]   iSOURCE1,
  output logic             oBUSY,
  output logic             oVALID,
  output logic [2*P_N-1:0] oDATA,
  output logic             oSF,
  output logic             oZF,
  output logic             oCF,
  output logic             oPF
);

  localparam int LP_STEPS = P_N / P_STEP;
  localparam int LP_CW    = $clog2(LP_STEPS + 1);
  localparam int LP_W     = 2 * P_N;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [LP_CW-1:0] r_cnt;
  logic [LP_W-1:0]  r_acc;
  logic [LP_W-1:0]  r_mcand;
  logic [P_N-1:0]   r_mplier;
  logic             r_neg;
  logic             r_signed;
  logic             r_busy;
  logic             r_valid;
  logic [LP_W-1:0]  r_data;
  logic             r_sf;
  logic             r_zf;
  logic             r_cf;
  logic             r_pf;

  logic             w_accept;
  logic             w_last;
  logic [LP_W-1:0]  w_pp;
  logic [LP_W-1:0]  w_acc_nxt;
  logic [LP_W-1:0]  w_res;
  logic [P_N-1:0]   w_hi;
  logic             w_cf;

  // Unsigned magnitude; the most negative value maps onto 2^(P_N-1) without overflow.
  function automatic logic [P_N-1:0] f_mag(input logic [P_N-1:0] x, input logic sgn);
    if (sgn && x[P_N-1]) begin
      f_mag = ~x + {{(P_N-1){1'b0}}, 1'b1};
    end else begin
      f_mag = x;
    end
  endfunction

  assign w_accept  = iVALID & ~iFLUSH & (r_state == ST_IDLE);
  assign w_last    = (r_cnt == LP_CW'(LP_STEPS - 1));
  assign w_pp      = r_mcand * {{(LP_W-P_STEP){1'b0}}, r_mplier[P_STEP-1:0]};
  assign w_acc_nxt = r_acc + w_pp;
  assign w_res     = r_neg ? (~w_acc_nxt + {{(LP_W-1){1'b0}}, 1'b1}) : w_acc_nxt;
  assign w_hi      = w_res[LP_W-1:P_N];
  // Signed overflow means the upper half is not a pure sign extension of the lower half.
  assign w_cf      = r_signed ? (w_hi != {P_N{w_res[P_N-1]}}) : (w_hi != {P_N{1'b0}});

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {LP_CW{1'b0}};
      r_acc    <= {LP_W{1'b0}};
      r_mcand  <= {LP_W{1'b0}};
      r_mplier <= {P_N{1'b0}};
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= {LP_W{1'b0}};
      r_sf     <= 1'b0;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
      r_pf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (w_accept) begin
            r_state  <= ST_CALC;
            r_busy   <= 1'b1;
            r_cnt    <= {LP_CW{1'b0}};
            r_acc    <= {LP_W{1'b0}};
            r_mcand  <= {{P_N{1'b0}}, f_mag(iSOURCE0, iSIGNED)};
            r_mplier <= f_mag(iSOURCE1, iSIGNED);
            r_neg    <= iSIGNED & (iSOURCE0[P_N-1] ^ iSOURCE1[P_N-1]);
            r_signed <= iSIGNED;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_CALC: begin
          if (iFLUSH) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << P_STEP;
            r_mplier <= r_mplier >> P_STEP;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
              r_data  <= w_res;
              r_sf    <= w_res[LP_W-1];
              r_zf    <= (w_res == {LP_W{1'b0}});
              r_cf    <= w_cf;
              r_pf    <= w_res[0];
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign oBUSY  = r_busy;
  assign oVALID = r_valid;
  assign oDATA  = r_data;
  assign oSF    = r_sf;
  assign oZF    = r_zf;
  assign oCF    = r_cf;
  assign oPF    = r_pf;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter at P_N=32, P_STEP=4: stimulus queues expectations
// tagged with the sample index, a negedge monitor compares and reports.
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        iRESET, iFLUSH, iVALID, iSIGNED;
  logic [31:0] iSOURCE0, iSOURCE1;
  logic        oBUSY, oVALID, oSF, oZF, oCF, oPF;
  logic [63:0] oDATA;

  mul_iter #(.P_N(32), .P_STEP(4)) dut (
    .iCLOCK(clk), .iRESET(iRESET), .iFLUSH(iFLUSH), .iVALID(iVALID),
    .iSIGNED(iSIGNED), .iSOURCE0(iSOURCE0), .iSOURCE1(iSOURCE1),
    .oBUSY(oBUSY), .oVALID(oVALID), .oDATA(oDATA),
    .oSF(oSF), .oZF(oZF), .oCF(oCF), .oPF(oPF)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [63:0] d; logic [3:0] f; } res_t;
  typedef struct { int cyc; logic busy; logic chk_data; logic [63:0] data; logic all_zero; } st_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic s; logic [63:0] d; logic [3:0] f; } vec_t;

  res_t q_res[$];
  st_t  q_st[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic done = 1'b0;
  logic [63:0] last_data;

  // Flags are packed as {SF, ZF, CF, PF}.
  vec_t vecs[12] = '{
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 4'b1011},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 4'b0001},
    '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, 4'b1000},
    '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 4'b0010},
    '{32'h12345678, 32'h00000000, 1'b0, 64'h0000000000000000, 4'b0100},
    '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 4'b0010},
    '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1, 4'b1001},
    '{32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780, 4'b0010},
    '{32'h00000007, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFFFFFFFFF2, 4'b1000},
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF, 4'b0001},
    '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF, 4'b1001},
    '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 64'h00000000FFFE0001, 4'b0011}
  };

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_st(input int c, input logic busy, input logic chk_data,
                         input logic [63:0] data, input logic all_zero);
    q_st.push_back('{cyc: c, busy: busy, chk_data: chk_data, data: data, all_zero: all_zero});
  endtask

  // Issue one request now; returns one sample later with scrambled operands.
  task automatic issue(input vec_t v, input logic do_res, input int n_busy);
    int c0;
    c0 = cyc;
    iSOURCE0 = v.a;
    iSOURCE1 = v.b;
    iSIGNED  = v.s;
    iVALID   = 1'b1;
    if (do_res) begin
      q_res.push_back('{cyc: c0 + 9, d: v.d, f: v.f});
      last_data = v.d;
    end
    for (int k = 1; k <= n_busy; k++) push_st(c0 + k, 1'b1, 1'b0, 64'd0, 1'b0);
    if (n_busy == 9) push_st(c0 + 10, 1'b0, 1'b1, v.d, 1'b0);
    step(1);
    iVALID   = 1'b0;
    iSOURCE0 = $urandom;
    iSOURCE1 = $urandom;
    iSIGNED  = ~v.s;
  endtask

  // Monitor: compare results and state expectations due at this sample.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (q_res.size() > 0 && q_res[0].cyc == cyc) begin
      n_chk = n_chk + 1;
      if (oVALID !== 1'b1 || oDATA !== q_res[0].d || {oSF, oZF, oCF, oPF} !== q_res[0].f) begin
        n_fail = n_fail + 1;
        $display("FAIL result@%0d: got valid=%b data=%h flags=%b, want valid=1 data=%h flags=%b",
                 cyc, oVALID, oDATA, {oSF, oZF, oCF, oPF}, q_res[0].d, q_res[0].f);
      end
      void'(q_res.pop_front());
    end else begin
      n_chk = n_chk + 1;
      if (oVALID !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL no_valid@%0d: got oVALID=%b, want 0", cyc, oVALID);
      end
    end
    for (int i = q_st.size() - 1; i >= 0; i--) begin
      if (q_st[i].cyc == cyc) begin
        n_chk = n_chk + 1;
        if (q_st[i].all_zero) begin
          if ({oBUSY, oVALID, oDATA, oSF, oZF, oCF, oPF} !== 70'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_zero@%0d: got busy=%b valid=%b data=%h flags=%b, want all 0",
                     cyc, oBUSY, oVALID, oDATA, {oSF, oZF, oCF, oPF});
          end
        end else if (oBUSY !== q_st[i].busy || (q_st[i].chk_data && oDATA !== q_st[i].data)) begin
          n_fail = n_fail + 1;
          $display("FAIL busy_hold@%0d: got busy=%b data=%h, want busy=%b data=%h (data checked=%b)",
                   cyc, oBUSY, oDATA, q_st[i].busy, q_st[i].data, q_st[i].chk_data);
        end
        q_st.delete(i);
      end
    end
    if (done) begin
      n_chk = n_chk + 1;
      if (q_res.size() != 0 || q_st.size() != 0) begin
        n_fail = n_fail + 1;
        $display("FAIL drain: got %0d results and %0d state checks pending, want 0 and 0",
                 q_res.size(), q_st.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  // Stimulus sequence.
  initial begin
    iRESET = 1'b1; iFLUSH = 1'b0; iVALID = 1'b0; iSIGNED = 1'b0;
    iSOURCE0 = 32'd0; iSOURCE1 = 32'd0; last_data = 64'd0;
    push_st(1, 1'b0, 1'b0, 64'd0, 1'b1);
    push_st(2, 1'b0, 1'b0, 64'd0, 1'b1);
    step(1);
    iRESET = 1'b0;
    step(1);

    foreach (vecs[n]) begin
      issue(vecs[n], 1'b1, 9);
      step(9);
    end

    // Flush has priority over a request in IDLE.
    iVALID = 1'b1; iFLUSH = 1'b1; iSOURCE0 = 32'h3; iSOURCE1 = 32'h3;
    push_st(cyc + 1, 1'b0, 1'b1, last_data, 1'b0);
    step(1);
    iVALID = 1'b0; iFLUSH = 1'b0;
    step(1);

    // Flush mid-CALC: abort, keep old result, then a fresh request completes.
    issue(vecs[0], 1'b0, 3);
    last_data = vecs[11].d;
    step(2);
    iFLUSH = 1'b1;
    push_st(cyc + 1, 1'b0, 1'b1, last_data, 1'b0);
    step(1);
    iFLUSH = 1'b0;
    issue(vecs[6], 1'b1, 9);
    step(9);

    // Flush while DONE does not retract the pulse.
    issue(vecs[2], 1'b1, 9);
    step(8);
    iFLUSH = 1'b1;
    step(1);
    iFLUSH = 1'b0;
    step(1);

    // Asynchronous reset mid-CALC, then 20 quiet cycles.
    issue(vecs[7], 1'b0, 4);
    step(3);
    @(posedge clk);
    #2;
    iRESET = 1'b1;
    push_st(cyc + 1, 1'b0, 1'b0, 64'd0, 1'b1);
    push_st(cyc + 2, 1'b0, 1'b0, 64'd0, 1'b1);
    step(2);
    iRESET = 1'b0;
    last_data = 64'd0;
    step(20);

    // Accept on the first edge after reset release.
    iRESET = 1'b1;
    step(1);
    iRESET = 1'b0;
    issue(vecs[8], 1'b1, 9);
    step(9);

    // iVALID held high: exactly one accept per 10 cycles.
    begin
      int c0;
      c0 = cyc;
      iSOURCE0 = vecs[3].a; iSOURCE1 = vecs[3].b; iSIGNED = vecs[3].s; iVALID = 1'b1;
      q_res.push_back('{cyc: c0 + 9,  d: vecs[3].d, f: vecs[3].f});
      q_res.push_back('{cyc: c0 + 19, d: vecs[3].d, f: vecs[3].f});
      push_st(c0 + 1,  1'b1, 1'b0, 64'd0, 1'b0);
      push_st(c0 + 9,  1'b1, 1'b0, 64'd0, 1'b0);
      push_st(c0 + 10, 1'b0, 1'b0, 64'd0, 1'b0);
      push_st(c0 + 11, 1'b1, 1'b0, 64'd0, 1'b0);
      push_st(c0 + 19, 1'b1, 1'b0, 64'd0, 1'b0);
      push_st(c0 + 20, 1'b0, 1'b1, vecs[3].d, 1'b0);
      step(11);
      iVALID = 1'b0;
      step(12);
    end

    done = 1'b1;
  end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 The block SHALL have parameter P_N, default 32, operand width in bits; legal values are multiples of P_STEP, with P_N >= 8.
REQ-002 The block SHALL have parameter P_STEP, default 4, multiplier bits retired per cycle; legal values are 1, 2, 4 and 8.
REQ-003 The block SHALL have port iCLOCK, in, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port iRESET, in, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port iFLUSH, in, 1 bit: synchronous abort of any operation in progress.
REQ-006 The block SHALL have port iVALID, in, 1 bit: request strobe, qualified by oBUSY=0.
REQ-007 The block SHALL have port iSIGNED, in, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with the request.
REQ-008 The block SHALL have ports iSOURCE0 and iSOURCE1, in, P_N bits each: multiplicand and multiplier; sampled with the request.
REQ-009 The block SHALL have port oBUSY, out, 1 bit: 1 while an operation is in progress; no request is accepted while it is 1.
REQ-010 The block SHALL have port oVALID, out, 1 bit: one-cycle pulse marking a completed result.
REQ-011 The block SHALL have port oDATA, out, 2*P_N bits: full-width product.
REQ-012 The block SHALL have ports oSF, oZF, oCF and oPF, out, 1 bit each: result flags, valid with oVALID.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE, all as registered state.
REQ-014 The block SHALL treat the handshake as accepted when iVALID=1, oBUSY=0 and iFLUSH=0 on a rising edge; accept SHALL move the FSM IDLE->CALC, register both operands and iSIGNED, and clear the step counter.
REQ-015 The block SHALL register operand magnitudes on accept: in signed mode, |x| SHALL be computed as an unsigned P_N-bit value (so 2^(P_N-1) is legal), and the result-negate bit SHALL be sign0 XOR sign1; in unsigned mode the operands SHALL be used as-is and negate SHALL be 0.
REQ-016 In each CALC cycle the block SHALL add multiplicand*(next P_STEP multiplier bits, LSB first), shifted to the correct weight, into a 2*P_N-bit accumulator, and SHALL increment the counter.
REQ-017 After exactly P_N/P_STEP CALC cycles the FSM SHALL go CALC->DONE; on that edge oDATA SHALL be loaded with the accumulator, two's-complement negated if the negate bit is 1, and the flags SHALL be loaded.
REQ-018 oVALID SHALL be 1 exactly while the state is DONE, which lasts one cycle, followed by DONE->IDLE; latency from the accept edge to oVALID=1 SHALL be P_N/P_STEP+1 cycles (9 at the defaults).
REQ-019 oBUSY SHALL be 1 in CALC and DONE and 0 in IDLE; the back-to-back issue interval SHALL therefore be P_N/P_STEP+2 cycles.
REQ-020 The flags SHALL be defined as: oSF = oDATA[2P_N-1]; oZF = (oDATA==0); oPF = oDATA[0]; oCF = 1 iff the product does not fit in P_N bits, meaning the upper half is nonzero in unsigned mode, or the upper half is not the sign extension of bit P_N-1 in signed mode.
REQ-021 oDATA and the flags SHALL hold their last value until the next DONE load.
REQ-022 iFLUSH=1 in CALC SHALL return the FSM to IDLE on the next edge with no oVALID pulse and oDATA unchanged.
REQ-023 iFLUSH=1 in DONE SHALL NOT retract the current oVALID, and the FSM SHALL still go to IDLE.
REQ-024 iFLUSH=1 takes priority over iVALID, so no accept SHALL occur in the same cycle.
REQ-025 Operand inputs SHALL be ignored outside the accept cycle; changing them mid-operation SHALL have no effect.

Reset
REQ-026 Asserting iRESET SHALL immediately force state=IDLE, counter=0, accumulator=0, oBUSY=0, oVALID=0, oDATA=0 and oSF=oZF=oCF=oPF=0, regardless of the clock.
REQ-027 Reset mid-operation SHALL discard the operation with no oVALID pulse, and the first accept SHALL be possible on the first edge after iRESET deasserts.

Verification (P_N=32, P_STEP=4)
REQ-028 The bench SHALL cover this scenario: unsigned 0xFFFFFFFF * 0xFFFFFFFF -> oVALID 9 cycles after accept, oDATA=0xFFFFFFFE00000001, SF=1, ZF=0, CF=1, PF=1, oBUSY high for 9 cycles.
REQ-029 The bench SHALL cover these signed cases: 0xFFFFFFFF * 0xFFFFFFFF -> oDATA=0x0000000000000001 with CF=0, SF=0; 0x80000000 * 0x00000001 -> oDATA=0xFFFFFFFF80000000 with CF=0, SF=1.
REQ-030 The bench SHALL cover signed 0x80000000 * 0x80000000 -> oDATA=0x4000000000000000, CF=1, SF=0; and unsigned 0x12345678 * 0 -> oDATA=0, ZF=1, CF=0, PF=0.
REQ-031 The bench SHALL cover this scenario: iFLUSH pulsed 3 cycles after accept -> oBUSY=0 on the next cycle, no oVALID, oDATA retains the previous result; a new request next cycle completes normally.
REQ-032 The bench SHALL cover this scenario: iRESET asserted asynchronously mid-CALC -> all outputs 0 immediately, no oVALID for 20 cycles; iVALID held high while busy -> exactly one accept per 10-cycle interval.
